// File: rtl/instr_encoder.sv
// Streams MIPS-style instructions into instruction memory starting at 0x3000, one word per cycle.
// Latency 1 cycle accept-to-write; in_ready drops while a pending write is stalled by im_ready=0.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        im_we,
  input  logic        im_ready,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic [10:0] word_count,
  output logic        err_illegal,
  output logic        err_trunc
);

  localparam logic [31:0] ADDR_BASE = 32'h0000_3000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      r_state;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [10:0] r_count;
  logic [10:0] r_acc;
  logic        r_err_ill;
  logic        r_err_trunc;
  logic        r_busy;
  logic        r_done;

  logic        w_acc;
  logic        w_cmp;
  logic        w_full;
  logic        w_illegal;
  logic [31:0] w_enc;

  assign in_ready = (r_state == S_RUN) & (~r_we | im_ready);
  assign w_acc    = in_valid & in_ready;
  assign w_cmp    = r_we & im_ready;
  assign w_full   = (r_acc == 11'd1023);

  // Only the fields an opcode actually uses reach the word; everything else is forced.
  always_comb begin
    w_enc     = 32'h0000_0000;
    w_illegal = 1'b0;
    case (in_op)
      4'd0:  w_enc = 32'h0000_0000;
      4'd1:  w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      4'd2:  w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      4'd3:  w_enc = {6'b000000, in_rs, 15'b0, 6'b001000};
      4'd4:  w_enc = {6'b001101, in_rs, in_rt, in_imm};
      4'd5:  w_enc = {6'b100011, in_rs, in_rt, in_imm};
      4'd6:  w_enc = {6'b101011, in_rs, in_rt, in_imm};
      4'd7:  w_enc = {6'b000100, in_rs, in_rt, in_imm};
      4'd8:  w_enc = {6'b001111, 5'b00000, in_rt, in_imm};
      4'd9:  w_enc = {6'b000011, in_target};
      4'd10: w_enc = {6'b100000, in_rs, in_rt, in_imm};
      4'd11: w_enc = {6'b101000, in_rs, in_rt, in_imm};
      default: begin
        w_enc     = 32'h0000_0000;
        w_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_addr      <= ADDR_BASE;
      r_wdata     <= 32'h0000_0000;
      r_count     <= 11'd0;
      r_acc       <= 11'd0;
      r_err_ill   <= 1'b0;
      r_err_trunc <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_addr      <= ADDR_BASE;
            r_count     <= 11'd0;
            r_acc       <= 11'd0;
            r_err_ill   <= 1'b0;
            r_err_trunc <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        S_RUN: begin
          // im_addr tracks the pending word, so it advances only on completion.
          if (w_cmp) begin
            r_addr  <= r_addr + 32'd4;
            r_count <= r_count + 11'd1;
          end
          if (w_acc) begin
            r_wdata <= w_enc;
            r_acc   <= r_acc + 11'd1;
            if (w_illegal) r_err_ill <= 1'b1;
            if (in_last || w_full) begin
              r_state <= S_DRAIN;
              if (!in_last) r_err_trunc <= 1'b1;
            end
          end
          r_we <= w_acc | (r_we & ~im_ready);
        end
        S_DRAIN: begin
          if (w_cmp) begin
            r_addr  <= r_addr + 32'd4;
            r_count <= r_count + 11'd1;
            r_we    <= 1'b0;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign im_we       = r_we;
  assign im_addr     = r_addr;
  assign im_wdata    = r_wdata;
  assign busy        = r_busy;
  assign done        = r_done;
  assign word_count  = r_count;
  assign err_illegal = r_err_ill;
  assign err_trunc   = r_err_trunc;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-low; 0 at a rising edge resets the block
- start  in  1  one-cycle pulse, begins a program load
- in_valid  in  1  source presents an instruction
- in_ready  out  1  block accepts; transfer when in_valid&in_ready at an edge
- in_op  in  4  0 nop, 1 add, 2 sub, 3 jr, 4 ori, 5 lw, 6 sw, 7 beq, 8 lui, 9 jal, 10 lb, 11 sb; 12-15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jal word target
- in_last  in  1  marks final instruction of program
- im_we  out  1  encoded word valid toward instruction memory
- im_ready  in  1  memory takes word; write completes when im_we&im_ready at an edge
- im_addr  out  32  byte address of im_wdata
- im_wdata  out  32  encoded MIPS word
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- word_count  out  11  words written this load
- err_illegal  out  1  sticky, illegal in_op accepted
- err_trunc  out  1  sticky, capacity reached before in_last

Function
REQ-002 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-003 IDLE/DONE + start -> RUN; on that edge im_addr=0x00003000, word_count=0, accepted count=0, both errors cleared; start in RUN/DRAIN ignored.
REQ-004 in_ready = (state==RUN) & (!im_we | im_ready); combinational, no dependence on in_valid.
REQ-005 Accepted instruction SHALL appear on im_wdata with im_we=1 on the next cycle (latency 1); sustained throughput 1 word/cycle while im_ready=1.
REQ-006 im_wdata/im_addr SHALL hold stable while im_we=1 & im_ready=0.
REQ-007 Each completed write: im_addr += 4, word_count += 1; accept and completion in the same cycle are both honoured.
REQ-008 Encoding: add/sub = {000000,rs,rt,rd,00000,funct 100000/100010}; jr = {000000,rs,15'b0,001000}; ori 001101, lw 100011, sw 101011, beq 000100, lb 100000, sb 101000 = {opc,rs,rt,imm}; lui = {001111,00000,rt,imm}; jal = {000011,target}; nop = 0x00000000.
REQ-009 Fields unused by an op SHALL be ignored (forced to the values in REQ-008).
REQ-010 Illegal in_op SHALL be accepted, encoded as 0x00000000, and set err_illegal.
REQ-011 Capacity 1024 words: accepting with in_last=1 or as the 1024th word -> DRAIN; 1024th with in_last=0 also sets err_trunc.
REQ-012 DRAIN: in_ready=0; when pending write completes -> DONE.
REQ-013 DONE holds done=1, im_we=0, word_count and errors frozen until start.
REQ-014 in_valid=0 in RUN SHALL not change state; no timeout.

Reset
REQ-015 reset=0 at an edge, in any state incl. mid-write: state IDLE, in_ready=0, im_we=0, im_addr=0x00003000, im_wdata=0, busy=0, done=0, word_count=0, err_illegal=0, err_trunc=0; pending word discarded.
REQ-016 reset SHALL take priority over start and all handshakes in the same cycle.

Verification
REQ-017 start; add rs1 rt2 rd3; ori rs0 rt1 imm0x1234 with in_last; im_ready=1 -> writes 0x00221820@0x3000, 0x34011234@0x3004, DONE, word_count=2.
REQ-018 lw rs2 rt4 imm8, jal 0x0000C03, beq rs1 rt2 imm0xFFFF, lui rt5 imm0xABCD, jr rs31 (rd/imm garbage) -> 0x8C440008, 0x0C000C03, 0x1022FFFF, 0x3C05ABCD, 0x03E00008.
REQ-019 im_ready=0 for 3 cycles with word pending -> in_ready=0, im_wdata/im_addr stable, no address advance; then resumes in order, no loss/duplication.
REQ-020 in_op=13 accepted -> 0x00000000 written, err_illegal=1 until next start.
REQ-021 1024 words, no in_last -> last write at 0x00003FFC, DONE, word_count=1024, err_trunc=1; further in_valid not accepted.
REQ-022 reset=0 while im_we=1 mid-program -> next cycle all outputs at REQ-015 values; start then reloads from 0x00003000.
